soc_simple_pll_reset_seq: RTL and testbench
===========================================

Name: soc_simple_pll_reset_seq

Overview:
Power-up and relock sequencer for the system PLL (50 MHz refclk in, 150 MHz out).
- Holds the PLL in reset for a fixed pulse, then waits for `locked` with a timeout and retries.
- Requires `locked` to stay continuously high before releasing the system reset.
- Re-sequences on lock loss or on software request.
- Runs entirely on refclk; sits between the board reset and the PLL/SoC reset tree.

Parameters:
- PLL_RST_CYCLES, 10, cycles pll_rst is held high per attempt (>=1).
- LOCK_TIMEOUT_CYCLES, 50000, cycles allowed in WAIT_LOCK before the attempt fails (>=1).
- LOCK_STABLE_CYCLES, 1024, consecutive synchronized-locked cycles required before release (>=1).
- MAX_RETRIES, 3, failed attempts retried before FAULT; total attempts = MAX_RETRIES+1.

Ports:
- refclk  in  1  sole clock (PLL reference domain)
- rst  in  1  synchronous, active-high reset
- pll_locked  in  1  PLL locked, asynchronous to refclk
- relock_req  in  1  single-cycle software request to re-sequence the PLL
- pll_rst  out  1  drives PLL rst
- sys_rst  out  1  active-high reset for the downstream domain
- ready  out  1  high while running with a stable lock
- fault  out  1  retries exhausted
- retry_count  out  $clog2(MAX_RETRIES+1)  failed attempts in the current sequence

Behaviour:
- One clock, refclk; rst is synchronous and active-high and overrides all other logic.
- Reset values:
  - state = PLL_RESET, cnt = 0, retry_count = 0, sync flops = 0.
  - pll_rst = 1, sys_rst = 1, ready = 0, fault = 0.
- pll_locked passes through a 2-flop synchronizer giving locked_s; latency is 2 cycles.
- All outputs decode from registered state only; there is no combinational path from any input to any output.
  - pll_rst = (PLL_RESET or FAULT).
  - sys_rst = (state != RUN).
  - ready = (state == RUN).
  - fault = (state == FAULT).
- A single shared counter cnt, wide enough for the largest limit, clears on every state change.
- State PLL_RESET:
  - cnt increments each cycle.
  - When cnt == PLL_RST_CYCLES-1, go to WAIT_LOCK.
  - Cycle 0 is the first cycle with rst low; pll_rst is high for cycles 0..PLL_RST_CYCLES-1.
- State WAIT_LOCK:
  - If locked_s, go to STABLE.
  - Else if cnt == LOCK_TIMEOUT_CYCLES-1:
    - If retry_count == MAX_RETRIES, go to FAULT.
    - Otherwise retry_count++ and go to PLL_RESET.
  - locked_s takes priority over timeout in the same cycle.
- State STABLE:
  - If !locked_s, return to WAIT_LOCK; the timeout restarts and retry_count is unchanged.
  - Else if cnt == LOCK_STABLE_CYCLES-1, go to RUN.
- State RUN:
  - retry_count clears on entry.
  - If !locked_s or relock_req, go to PLL_RESET; sys_rst asserts on the next cycle.
  - Simultaneous lock loss and relock_req are a single transition.
- State FAULT:
  - Held until rst or relock_req.
  - relock_req goes to PLL_RESET with retry_count = 0.
- relock_req is ignored in PLL_RESET, WAIT_LOCK and STABLE.
- rst asserted mid-sequence returns immediately to the reset values; no partial state survives.
- retry_count saturates at MAX_RETRIES and never wraps.

Decomposition:
- Package soc_simple_pll_seq_pkg holds:
  - the state enum (PLL_RESET, WAIT_LOCK, STABLE, RUN, FAULT);
  - a localparam function for counter width, max of the three cycle limits.
- Sub-module soc_simple_sync2: 2-flop synchronizer with synchronous active-high reset to 0; reused for other async status inputs.

Test Plan (PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2):
- Release rst at cycle 0 with pll_locked=0 -> pll_rst=1 for cycles 0-3, 0 from cycle 4; sys_rst=1 throughout.
- pll_locked rises before cycle 10 and stays high:
  - locked_s high at cycle 12; STABLE for cycles 13-20; RUN at cycle 21.
  - sys_rst=0 and ready=1 at cycle 21; retry_count=0.
- pll_locked never rises:
  - retry_count goes to 1 at cycle 24 and 2 at cycle 48.
  - FAULT at cycle 72: fault=1, pll_rst=1, sys_rst=1.
  - Later relock_req -> PLL_RESET, fault=0, retry_count=0.
- In STABLE, drop pll_locked for 1 cycle at stable cnt=5 -> back to WAIT_LOCK; RUN delayed by a full 8 stable cycles; retry_count unchanged.
- In RUN, pulse relock_req and drop pll_locked in the same cycle -> one transition; sys_rst=1 next cycle; pll_rst high for exactly 4 cycles.
- Assert rst for 1 cycle while in STABLE -> all outputs return to reset values the next cycle; sequence restarts from cycle 0.

Source files
------------

// File: rtl/soc_simple_pll_reset_seq_pkg.sv
// Shared types and helpers for the PLL power-up / relock sequencer.
package soc_simple_pll_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RESET,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAULT
    } pll_seq_state_e;

    // One shared counter serves every timed state, so it is sized for the longest limit.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/soc_simple_pll_reset_seq_sync2.sv
// Two-flop synchronizer for asynchronous status inputs; clears to 0 on reset.
module soc_simple_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/soc_simple_pll_reset_seq.sv
// PLL reset sequencer: pulses pll_rst, waits for a stable lock with timeout/retry,
// then releases sys_rst; re-sequences on lock loss or software request.
module soc_simple_pll_reset_seq
    import soc_simple_pll_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES      = 10,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3,
    localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               pll_locked,
    input  logic               relock_req,
    output logic               pll_rst,
    output logic               sys_rst,
    output logic               ready,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_count
);

    localparam int CNT_W = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
    localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

    pll_seq_state_e   state;
    pll_seq_state_e   next_state;
    logic [CNT_W-1:0] cnt;
    logic             locked_s;

    soc_simple_sync2 u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    // The counter only runs in the timed states and restarts on every state change.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state       <= PLL_RESET;
            cnt         <= '0;
            retry_count <= '0;
        end else begin
            state <= next_state;
            if (next_state != state)
                cnt <= '0;
            else if (state == PLL_RESET || state == WAIT_LOCK || state == STABLE)
                cnt <= cnt + 1'b1;

            if (next_state == RUN || (state == FAULT && next_state == PLL_RESET))
                retry_count <= '0;
            else if (state == WAIT_LOCK && next_state == PLL_RESET && retry_count != RETRY_MAX)
                retry_count <= retry_count + 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            PLL_RESET: begin
                if (cnt == RST_LAST) next_state = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (locked_s)
                    next_state = STABLE;
                else if (cnt == TIMEOUT_LAST)
                    next_state = (retry_count == RETRY_MAX) ? FAULT : PLL_RESET;
            end
            STABLE: begin
                if (!locked_s)
                    next_state = WAIT_LOCK;
                else if (cnt == STABLE_LAST)
                    next_state = RUN;
            end
            RUN: begin
                if (!locked_s || relock_req) next_state = PLL_RESET;
            end
            FAULT: begin
                if (relock_req) next_state = PLL_RESET;
            end
            default: next_state = PLL_RESET;
        endcase
    end

    always_comb begin
        pll_rst = (state == PLL_RESET) || (state == FAULT);
        sys_rst = (state != RUN);
        ready   = (state == RUN);
        fault   = (state == FAULT);
    end

endmodule

// File: tb/tb_soc_simple_pll_reset_seq.sv
// Randomized scoreboard bench for soc_simple_pll_reset_seq against a deadline-based model.
module tb_soc_simple_pll_reset_seq;

    localparam int P_RST    = 4;
    localparam int P_TO     = 20;
    localparam int P_STABLE = 8;
    localparam int P_MAX    = 2;

    localparam int PH_RST   = 0;
    localparam int PH_WAIT  = 1;
    localparam int PH_STAB  = 2;
    localparam int PH_RUN   = 3;
    localparam int PH_FAULT = 4;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fault;
    logic [1:0] retry_count;

    typedef struct packed {
        logic       pll_rst;
        logic       sys_rst;
        logic       ready;
        logic       fault;
        logic [1:0] retry;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    int   m_phase;
    int   m_deadline;
    int   m_cyc;
    int   m_retries;
    bit   m_hist[$];

    int   mode;
    int   seg_len;
    bit   lk_state;
    bit   r_bit;
    bit   rq_bit;

    always #10 refclk = ~refclk;

    soc_simple_pll_reset_seq #(
        .PLL_RST_CYCLES      (P_RST),
        .LOCK_TIMEOUT_CYCLES (P_TO),
        .LOCK_STABLE_CYCLES  (P_STABLE),
        .MAX_RETRIES         (P_MAX)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .relock_req  (relock_req),
        .pll_rst     (pll_rst),
        .sys_rst     (sys_rst),
        .ready       (ready),
        .fault       (fault),
        .retry_count (retry_count)
    );

    // Model: each phase entered at cycle t has a last cycle t+len-1; locked_s is pll_locked two cycles late.
    function automatic void m_enter(input int ph, input int start);
        m_phase = ph;
        case (ph)
            PH_RST:  m_deadline = start + P_RST - 1;
            PH_WAIT: m_deadline = start + P_TO - 1;
            PH_STAB: m_deadline = start + P_STABLE - 1;
            default: m_deadline = -1;
        endcase
    endfunction

    function automatic void model_step(input bit r, input bit lk, input bit rq);
        bit ls;
        int nxt;
        if (r) begin
            m_cyc = 0;
            m_retries = 0;
            m_hist = {1'b0, 1'b0};
            m_enter(PH_RST, 0);
        end else begin
            ls = m_hist[0];
            nxt = m_phase;
            case (m_phase)
                PH_RST:  if (m_cyc == m_deadline) nxt = PH_WAIT;
                PH_WAIT: begin
                    if (ls) nxt = PH_STAB;
                    else if (m_cyc == m_deadline) begin
                        if (m_retries >= P_MAX) nxt = PH_FAULT;
                        else begin
                            m_retries = m_retries + 1;
                            nxt = PH_RST;
                        end
                    end
                end
                PH_STAB: begin
                    if (!ls) nxt = PH_WAIT;
                    else if (m_cyc == m_deadline) nxt = PH_RUN;
                end
                PH_RUN:  if (!ls || rq) nxt = PH_RST;
                default: if (rq) begin
                    nxt = PH_RST;
                    m_retries = 0;
                end
            endcase
            if (nxt == PH_RUN) m_retries = 0;
            void'(m_hist.pop_front());
            m_hist.push_back(lk);
            m_cyc = m_cyc + 1;
            if (nxt != m_phase) m_enter(nxt, m_cyc);
        end
    endfunction

    function automatic exp_t m_expect();
        exp_t e;
        e.pll_rst = (m_phase == PH_RST) || (m_phase == PH_FAULT);
        e.sys_rst = (m_phase != PH_RUN);
        e.ready   = (m_phase == PH_RUN);
        e.fault   = (m_phase == PH_FAULT);
        e.retry   = 2'(m_retries);
        return e;
    endfunction

    task automatic applyStimulus(input bit r, input bit lk, input bit rq);
        @(negedge refclk);
        rst = r;
        pll_locked = lk;
        relock_req = rq;
        model_step(r, lk, rq);
        exp_q.push_back(m_expect());
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s t=%0t got=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    // Monitor: every clock edge presents one registered output word to compare.
    always @(posedge refclk) begin
        exp_t e;
        exp_t act;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            act = {pll_rst, sys_rst, ready, fault, retry_count};
            checks++;
            if (act !== e) begin
                failures++;
                $display("[TB] FAIL scoreboard t=%0t got pll_rst=%b sys_rst=%b ready=%b fault=%b retry=%0d expected pll_rst=%b sys_rst=%b ready=%b fault=%b retry=%0d",
                         $time, act.pll_rst, act.sys_rst, act.ready, act.fault, act.retry,
                         e.pll_rst, e.sys_rst, e.ready, e.fault, e.retry);
            end
        end
    end

    initial begin
        // Lock arrives at cycle 10, RUN at 21, then a combined relock/lock-loss.
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int c = 0; c <= 29; c++) begin
            applyStimulus(1'b0, (c >= 10 && c != 23), (c == 23));
            if (c == 0)  checkOutput("reset_pll_rst_c0", pll_rst, 1);
            if (c == 0)  checkOutput("reset_sys_rst_c0", sys_rst, 1);
            if (c == 3)  checkOutput("pll_rst_c3", pll_rst, 1);
            if (c == 4)  checkOutput("pll_rst_c4", pll_rst, 0);
            if (c == 20) checkOutput("sys_rst_c20", sys_rst, 1);
            if (c == 21) checkOutput("sys_rst_c21", sys_rst, 0);
            if (c == 21) checkOutput("ready_c21", ready, 1);
            if (c == 21) checkOutput("retry_c21", retry_count, 0);
            if (c == 24) checkOutput("relock_sys_rst_c24", sys_rst, 1);
            if (c == 27) checkOutput("relock_pll_rst_c27", pll_rst, 1);
            if (c == 28) checkOutput("relock_pll_rst_c28", pll_rst, 0);
        end

        // Lock never arrives: retries, FAULT, then software relock.
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int c = 0; c <= 81; c++) begin
            applyStimulus(1'b0, 1'b0, (c == 80));
            if (c == 23) checkOutput("retry_c23", retry_count, 0);
            if (c == 24) checkOutput("retry_c24", retry_count, 1);
            if (c == 48) checkOutput("retry_c48", retry_count, 2);
            if (c == 71) checkOutput("fault_c71", fault, 0);
            if (c == 72) checkOutput("fault_c72", fault, 1);
            if (c == 72) checkOutput("fault_pll_rst_c72", pll_rst, 1);
            if (c == 72) checkOutput("fault_sys_rst_c72", sys_rst, 1);
            if (c == 81) checkOutput("relock_fault_c81", fault, 0);
            if (c == 81) checkOutput("relock_retry_c81", retry_count, 0);
            if (c == 81) checkOutput("relock_pll_rst_c81", pll_rst, 1);
        end

        // Random segments: steady lock, no lock, or glitchy lock, with sparse relock and rst.
        lk_state = 1'b0;
        for (int s = 0; s < 40; s++) begin
            mode = $urandom_range(0, 2);
            seg_len = $urandom_range(20, 150);
            for (int i = 0; i < seg_len; i++) begin
                r_bit = ($urandom_range(0, 299) == 0);
                rq_bit = ($urandom_range(0, 39) == 0);
                case (mode)
                    0: lk_state = 1'b1;
                    1: lk_state = 1'b0;
                    default: if ($urandom_range(0, 7) == 0) lk_state = ~lk_state;
                endcase
                applyStimulus(r_bit, lk_state, rq_bit);
            end
        end

        repeat (3) @(posedge refclk);
        #2;
        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
